// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity modes and parity helper shared by the UART blocks
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;
  localparam logic [1:0] UART_PAR_NONE = 2'b00;
  localparam logic [1:0] UART_PAR_ODD  = 2'b01;
  localparam logic [1:0] UART_PAR_EVEN = 2'b10;
  localparam logic [1:0] UART_PAR_MARK = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP,
    S_BREAK  = ST_BREAK
  } uart_state_e;
  // x is the XOR reduction of the data word
  function automatic logic uart_parity(input logic [1:0] mode, input logic x);
    return mode == UART_PAR_MARK ? 1'b1 : mode == UART_PAR_ODD ? ~x : x;
  endfunction
endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: word handshake between a host source (master) and the transmitter (slave)
//   data  : word to send, LSB first
//   valid : data valid
//   ready : transmitter holding register empty
interface uart_tx_cfg_if #(parameter int p_data_bits = 8) ();
  logic [p_data_bits-1:0] data;
  logic                   valid;
  logic                   ready;
  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer, one-cycle tick every divisor clocks while enabled
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : count enable; counter held at 0 while low
//   divisor_i    : clocks per bit, 0 and 1 behave as 2
//   tick_o       : high on the last clock of each bit period
module uart_baud_tick #(parameter int p_div_width = 16) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [p_div_width-1:0] divisor_i,
  output logic                   tick_o
);
  logic [p_div_width-1:0] r_cnt;
  logic [p_div_width-1:0] w_div;
  always_comb begin
    w_div  = divisor_i < p_div_width'(2) ? p_div_width'(2) : divisor_i;
    tick_o = en_i && r_cnt == w_div - p_div_width'(1);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i || tick_o) r_cnt <= '0;
    else r_cnt <= r_cnt + p_div_width'(1);
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with one-word holding register and break
//   clk_i, rst_i   : clock, synchronous active-high reset
//   tx_if          : data/valid/ready word handshake (slave side)
//   divisor_i      : clocks per bit; parity_mode_i: none/odd/even/mark; stop_sel_i: 1 or 2 stops
//   break_i        : hold the line low while high
//   tx_o           : registered serial line; busy_o: FSM not idle; frame_done_o: end of last stop bit
module uart_tx_cfg import uart_pkg::*; #(
  parameter int p_data_bits = 8,
  parameter int p_div_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  uart_tx_cfg_if.slave           tx_if,
  input  logic [p_div_width-1:0] divisor_i,
  input  logic [1:0]             parity_mode_i,
  input  logic                   stop_sel_i,
  input  logic                   break_i,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);
  uart_state_e            r_state;
  logic [p_data_bits-1:0] r_hold, r_shift;
  logic                   r_full, r_par, r_two, r_brk, r_tx;
  logic [1:0]             r_pmode;
  logic [p_div_width-1:0] r_div;
  logic [3:0]             r_bits;
  logic                   w_tick, w_en, w_end, w_load, w_brk;
  uart_baud_tick #(.p_div_width(p_div_width)) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (w_en),
    .divisor_i(r_div),
    .tick_o   (w_tick)
  );
  // w_end: last clock of the final stop bit; frame boundaries decide break/next word/idle
  always_comb begin
    w_en         = r_state != S_IDLE && r_state != S_BREAK;
    w_end        = r_state == S_STOP && w_tick && r_bits == {3'b000, r_two};
    w_brk        = break_i && (r_state == S_IDLE || w_end);
    w_load       = !break_i && r_full && (r_state == S_IDLE || w_end);
    frame_done_o = w_end && !r_brk;
    tx_o         = r_tx;
    busy_o       = r_state != S_IDLE;
    tx_if.ready  = !r_full;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_full  <= 1'b0;
      r_hold  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_two   <= 1'b0;
      r_brk   <= 1'b0;
      r_pmode <= UART_PAR_NONE;
      r_div   <= '0;
      r_bits  <= '0;
    end else begin
      if (tx_if.valid && !r_full) begin
        r_hold <= tx_if.data;
        r_full <= 1'b1;
      end
      if (w_load) begin
        r_state <= S_START;
        r_tx    <= 1'b0;
        r_full  <= 1'b0;
        r_shift <= r_hold;
        r_par   <= uart_parity(parity_mode_i, ^r_hold);
        r_pmode <= parity_mode_i;
        r_two   <= stop_sel_i;
        r_div   <= divisor_i;
        r_brk   <= 1'b0;
        r_bits  <= '0;
      end else if (w_brk) begin
        r_state <= S_BREAK;
        r_tx    <= 1'b0;
        r_div   <= divisor_i;
      end else begin
        case (r_state)
          S_START: if (w_tick) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bits  <= '0;
          end
          S_DATA: if (w_tick) begin
            if (r_bits == 4'(p_data_bits - 1)) begin
              r_state <= r_pmode == UART_PAR_NONE ? S_STOP : S_PARITY;
              r_tx    <= r_pmode == UART_PAR_NONE ? 1'b1 : r_par;
              r_bits  <= '0;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bits  <= r_bits + 4'd1;
            end
          end
          S_PARITY: if (w_tick) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
          S_STOP: if (w_tick) begin
            if (w_end) begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end else r_bits <= r_bits + 4'd1;
          end
          // the mark after a break is always two periods and never reports frame_done
          S_BREAK: if (!break_i) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_bits  <= '0;
            r_two   <= 1'b1;
            r_brk   <= 1'b1;
          end
          default: r_tx <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed vector table plus hand sequences for streaming, break, reset and 5-bit mode
module tb_uart_tx_cfg;
  import uart_pkg::*;
  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  pm;
    logic        ss;
    int          eff;
    int          nbits;
    logic [11:0] bits;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] div8, div5;
  logic [1:0]  pm8, pm5;
  logic        ss8, ss5, brk8, brk5;
  logic        tx8, busy8, fd8, tx5, busy5, fd5;
  int checks = 0;
  int failures = 0;
  vec_t vecs[6];
  logic [7:0] words[3];
  uart_tx_cfg_if #(.p_data_bits(8)) if8 ();
  uart_tx_cfg_if #(.p_data_bits(5)) if5 ();
  always #5 clk = ~clk;
  uart_tx_cfg #(.p_data_bits(8), .p_div_width(16)) dut8 (
    .clk_i(clk), .rst_i(rst), .tx_if(if8), .divisor_i(div8), .parity_mode_i(pm8),
    .stop_sel_i(ss8), .break_i(brk8), .tx_o(tx8), .busy_o(busy8), .frame_done_o(fd8)
  );
  uart_tx_cfg #(.p_data_bits(5), .p_div_width(16)) dut5 (
    .clk_i(clk), .rst_i(rst), .tx_if(if5), .divisor_i(div5), .parity_mode_i(pm5),
    .stop_sel_i(ss5), .break_i(brk5), .tx_o(tx5), .busy_o(busy5), .frame_done_o(fd5)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic send_frame(input vec_t v, input string tag);
    int fd_cnt, fd_pos, nbad;
    fd_cnt = 0;
    fd_pos = -1;
    @(negedge clk);
    chk({tag, " ready_idle"}, if8.ready, 1);
    if8.data = v.data; if8.valid = 1'b1; div8 = v.div; pm8 = v.pm; ss8 = v.ss;
    @(negedge clk);
    if8.valid = 1'b0;
    chk({tag, " ready_drop"}, if8.ready, 0);
    chk({tag, " pre_start_tx"}, tx8, 1);
    @(negedge clk);
    div8 = 16'd7; pm8 = ~v.pm; ss8 = ~v.ss;
    for (int i = 0; i < v.nbits; i++) begin
      nbad = 0;
      for (int c = 0; c < v.eff; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (tx8 !== v.bits[i]) nbad++;
        if (fd8) begin fd_cnt++; fd_pos = i * v.eff + c; end
      end
      chk($sformatf("%s bit%0d_bad_clocks", tag, i), nbad, 0);
    end
    chk({tag, " busy_in_frame"}, busy8, 1);
    chk({tag, " frame_done_count"}, fd_cnt, 1);
    chk({tag, " frame_done_pos"}, fd_pos, v.nbits * v.eff - 1);
    @(negedge clk);
    chk({tag, " busy_after"}, busy8, 0);
    chk({tag, " tx_after"}, tx8, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, acc, nbad, fdbad, busybad;
    logic adv, started, lvl;
    logic got_tx[60];
    logic got_fd[60];
    vecs[0] = '{8'hA5, 16'd4, UART_PAR_NONE, 1'b0, 4, 10, 12'b001101001010};
    vecs[1] = '{8'h07, 16'd3, UART_PAR_EVEN, 1'b1, 3, 12, 12'b111000001110};
    vecs[2] = '{8'h07, 16'd3, UART_PAR_ODD,  1'b1, 3, 12, 12'b110000001110};
    vecs[3] = '{8'h00, 16'd2, UART_PAR_MARK, 1'b0, 2, 11, 12'b011000000000};
    vecs[4] = '{8'hFF, 16'd5, UART_PAR_EVEN, 1'b0, 5, 11, 12'b010111111110};
    vecs[5] = '{8'h3C, 16'd1, UART_PAR_NONE, 1'b1, 2, 11, 12'b011001111000};
    words[0] = 8'h55; words[1] = 8'h0F; words[2] = 8'hC3;
    rst = 1'b1;
    if8.data = '0; if8.valid = 1'b0; div8 = 16'd4; pm8 = UART_PAR_NONE; ss8 = 1'b0; brk8 = 1'b0;
    if5.data = '0; if5.valid = 1'b0; div5 = 16'd0; pm5 = UART_PAR_MARK; ss5 = 1'b0; brk5 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tx8", tx8, 1); chk("rst ready8", if8.ready, 1);
    chk("rst busy8", busy8, 0); chk("rst fd8", fd8, 0);
    chk("rst tx5", tx5, 1); chk("rst ready5", if5.ready, 1);
    chk("rst busy5", busy5, 0); chk("rst fd5", fd5, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) send_frame(vecs[i], $sformatf("vec%0d", i));
    // three words streamed with valid held high
    @(negedge clk);
    div8 = 16'd2; pm8 = UART_PAR_NONE; ss8 = 1'b0;
    if8.data = words[0]; if8.valid = 1'b1;
    n = 0; acc = 0; adv = 1'b0; started = 1'b0;
    for (int cyc = 0, idx = 0; cyc < 300 && n < 60; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (adv) begin
        idx++;
        if (idx < 3) if8.data = words[idx];
        else if8.valid = 1'b0;
      end
      adv = if8.valid && if8.ready;
      if (adv) acc++;
      if (started || tx8 === 1'b0) begin
        started = 1'b1;
        got_tx[n] = tx8; got_fd[n] = fd8; n++;
      end
    end
    chk("stream samples", n, 60);
    chk("stream accepts", acc, 3);
    nbad = 0; fdbad = 0;
    for (int k = 0; k < n; k++) begin
      lvl = (k % 20) / 2 == 0 ? 1'b0 : (k % 20) / 2 == 9 ? 1'b1 : words[k / 20][(k % 20) / 2 - 1];
      if (got_tx[k] !== lvl) nbad++;
      if (got_fd[k] !== (k % 20 == 19)) fdbad++;
    end
    chk("stream tx_bad_clocks", nbad, 0);
    chk("stream frame_done_bad_clocks", fdbad, 0);
    @(negedge clk);
    chk("stream busy_after", busy8, 0);
    // break requested mid-frame
    @(negedge clk);
    div8 = 16'd4; pm8 = UART_PAR_NONE; ss8 = 1'b0;
    if8.data = 8'hA5; if8.valid = 1'b1;
    @(negedge clk);
    if8.valid = 1'b0;
    @(negedge clk);
    nbad = 0; fdbad = 0; busybad = 0;
    for (int s = 0; s < 85; s++) begin
      if (s != 0) @(negedge clk);
      lvl = s < 40 ? vecs[0].bits[s / 4] : s <= 60 ? 1'b0 : 1'b1;
      if (tx8 !== lvl) nbad++;
      if (fd8 !== (s == 39)) fdbad++;
      if (busy8 !== (s <= 68)) busybad++;
      if (s == 10) brk8 = 1'b1;
      if (s == 45) div8 = 16'd9;
      if (s == 60) brk8 = 1'b0;
    end
    chk("break tx_bad_clocks", nbad, 0);
    chk("break frame_done_bad_clocks", fdbad, 0);
    chk("break busy_bad_clocks", busybad, 0);
    // reset during DATA with a second word held
    @(negedge clk);
    div8 = 16'd4; pm8 = UART_PAR_NONE; ss8 = 1'b0;
    if8.data = 8'hA5; if8.valid = 1'b1;
    @(negedge clk);
    if8.valid = 1'b0;
    @(negedge clk);
    chk("rstmid start_tx", tx8, 0);
    @(negedge clk);
    chk("rstmid ready_after_transfer", if8.ready, 1);
    if8.data = 8'h3C; if8.valid = 1'b1;
    @(negedge clk);
    if8.valid = 1'b0;
    chk("rstmid hold_full", if8.ready, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid tx", tx8, 1); chk("rstmid ready", if8.ready, 1);
    chk("rstmid busy", busy8, 0); chk("rstmid fd", fd8, 0);
    rst = 1'b0;
    nbad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || busy8 !== 1'b0) nbad++;
    end
    chk("rstmid held_word_discarded_bad_clocks", nbad, 0);
    send_frame(vecs[0], "post_rst");
    // 5-bit instance, mark parity, divisor 0 acts as 2
    @(negedge clk);
    if5.data = 5'h1F; if5.valid = 1'b1;
    @(negedge clk);
    if5.valid = 1'b0;
    @(negedge clk);
    nbad = 0; fdbad = 0;
    for (int s = 0; s < 16; s++) begin
      if (s != 0) @(negedge clk);
      if (tx5 !== (s >= 2)) nbad++;
      if (fd5 !== (s == 15)) fdbad++;
    end
    chk("dw5 tx_bad_clocks", nbad, 0);
    chk("dw5 frame_done_bad_clocks", fdbad, 0);
    @(negedge clk);
    chk("dw5 busy_after", busy5, 0);
    chk("dw5 tx_after", tx5, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
